// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width default, NOP encoding, fetch FSM states.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise bubble.
module if_id_reg #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       instr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       instr_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              valid_q;

    // Pipeline register update with flush/hold/load/bubble priority.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            pc_q    <= pc_q;
            instr_q <= instr_q;
            valid_q <= valid_q;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end else begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: req/ack fetch from instruction memory into IF/ID,
// with a one-entry skid buffer for decode stalls and squashing on branch flush.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter logic [31:0] NOP    = NOP_INSTR
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              id_stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              pc_stall_o,
    output logic [ADDR_W-1:0] if_id_pc_o,
    output logic [31:0]       if_id_instr_o,
    output logic              if_id_valid_o
);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] buf_pc_q;
    logic [31:0]       buf_instr_q;

    logic              issue;
    logic              accept;
    logic              buf_load;
    logic [ADDR_W-1:0] ld_pc;
    logic [31:0]       ld_instr;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) state_d = StReq;
            end
            StReq: begin
                if (mem_ack_i) begin
                    if (flush_i)         state_d = StIdle;
                    else if (id_stall_i) state_d = StHold;
                    else                 state_d = StIdle;
                end else if (flush_i) begin
                    state_d = StDrop;
                end
            end
            StHold: begin
                if (flush_i || !id_stall_i) state_d = StIdle;
            end
            StDrop: begin
                // Squashed fetch: wait out the ack, flushes here only redirect the PC.
                if (mem_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: issue, accept, buffer capture and IF/ID load source.
    always_comb begin
        issue    = (state_q == StIdle) && start_i && !flush_i;
        accept   = 1'b0;
        buf_load = 1'b0;
        ld_pc    = mem_addr_q;
        ld_instr = mem_rdata_i;
        unique case (state_q)
            StReq: begin
                accept   = mem_ack_i && !flush_i && !id_stall_i;
                buf_load = mem_ack_i && !flush_i && id_stall_i;
            end
            StHold: begin
                accept   = !id_stall_i && !flush_i;
                ld_pc    = buf_pc_q;
                ld_instr = buf_instr_q;
            end
            default: ;
        endcase
        pc_stall_o = !(accept || flush_i);
    end

    // Memory request/address registers and the skid buffer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else begin
            mem_req_q <= (state_d == StReq) || (state_d == StDrop);
            if (issue) begin
                mem_addr_q <= pc_i;
            end
            if (buf_load) begin
                buf_pc_q    <= mem_addr_q;
                buf_instr_q <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .NOP    (NOP)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .hold_i  (id_stall_i),
        .load_i  (accept),
        .pc_i    (ld_pc),
        .instr_i (ld_instr),
        .pc_o    (if_id_pc_o),
        .instr_o (if_id_instr_o),
        .valid_o (if_id_valid_o)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic, checked against a
// transaction-level model (outstanding fetch, squash flag, buffered entry, PC).
module tb_ifetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        id_stall_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        pc_stall_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;

    int total = 0;
    int bad = 0;

    // Model state.
    logic        m_pend, m_squash, m_buf;
    logic [31:0] m_addr, m_bpc, m_binstr;
    logic [31:0] m_vpc, m_vinstr;
    logic        m_vvalid;
    logic [31:0] pc_m;

    ifetch_unit u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .id_stall_i    (id_stall_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .pc_stall_o    (pc_stall_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_valid_o (if_id_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_squash = 1'b0; m_buf = 1'b0;
        m_addr = '0; m_bpc = '0; m_binstr = '0;
        m_vpc = '0; m_vinstr = 32'h0000_0000; m_vvalid = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check, then advance the model for the next posedge.
    task automatic step(input logic s, input logic f, input logic st, input logic a,
                        input logic [31:0] rd, input logic [31:0] tgt);
        logic        acc;
        logic [31:0] lpc, lin;
        @(negedge clk_i);
        start_i = s; flush_i = f; id_stall_i = st; mem_ack_i = a; mem_rdata_i = rd;
        pc_i = pc_m;
        #1;
        chk("ifid_pc", if_id_pc_o, m_vpc);
        chk("ifid_instr", if_id_instr_o, m_vinstr);
        chk("ifid_valid", {31'b0, if_id_valid_o}, {31'b0, m_vvalid});
        chk("mem_req", {31'b0, mem_req_o}, {31'b0, m_pend});
        chk("mem_addr", mem_addr_o, m_addr);
        acc = 1'b0; lpc = '0; lin = '0;
        if (m_buf) begin
            if (f) begin
                m_buf = 1'b0;
            end else if (!st) begin
                acc = 1'b1; lpc = m_bpc; lin = m_binstr; m_buf = 1'b0;
            end
        end else if (m_pend) begin
            if (a) begin
                m_pend = 1'b0;
                if (!m_squash && !f) begin
                    if (st) begin
                        m_buf = 1'b1; m_bpc = m_addr; m_binstr = rd;
                    end else begin
                        acc = 1'b1; lpc = m_addr; lin = rd;
                    end
                end
            end else if (f) begin
                m_squash = 1'b1;
            end
        end else if (s && !f) begin
            m_pend = 1'b1; m_squash = 1'b0; m_addr = pc_m;
        end
        chk("pc_stall", {31'b0, pc_stall_o}, {31'b0, ~(acc | f)});
        if (f) begin
            m_vpc = '0; m_vinstr = 32'h0; m_vvalid = 1'b0;
        end else if (!st) begin
            if (acc) begin
                m_vpc = lpc; m_vinstr = lin; m_vvalid = 1'b1;
            end else begin
                m_vpc = '0; m_vinstr = 32'h0; m_vvalid = 1'b0;
            end
        end
        if (f) pc_m = tgt;
        else if (acc) pc_m = pc_m + 32'd4;
    endtask

    // Look at registered outputs just after the edge that follows a step.
    task automatic peek(input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_v);
        @(posedge clk_i);
        #1;
        chk("peek_pc", if_id_pc_o, e_pc);
        chk("peek_instr", if_id_instr_o, e_instr);
        chk("peek_valid", {31'b0, if_id_valid_o}, {31'b0, e_v});
    endtask

    initial begin
        model_reset();
        pc_m = 32'h0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Zero-wait fetch from 0x0.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1, 32'h8C01_0004, 32'h0);
        peek(32'h0, 32'h8C01_0004, 1'b1);

        // Three wait states at 0x10.
        pc_m = 32'h10;
        step(1, 0, 0, 0, 32'h0, 32'h0);
        repeat (3) step(1, 0, 0, 0, 32'h1111_1111, 32'h0);
        step(1, 0, 0, 1, 32'h2222_2222, 32'h0);
        peek(32'h10, 32'h2222_2222, 1'b1);

        // Decode stall at ack, then release from the buffer.
        pc_m = 32'h14;
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 1, 1, 32'h0022_1820, 32'h0);
        step(1, 0, 1, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        peek(32'h14, 32'h0022_1820, 1'b1);

        // Flush while a request to 0x18 is pending; redirect to 0x40.
        pc_m = 32'h18;
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 0, 0, 32'h0, 32'h40);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1, 32'hDEAD_BEEF, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        chk("redirect_addr", mem_addr_o, 32'h40);

        // Flush coincident with ack; redirect to 0x80.
        step(1, 1, 0, 1, 32'hBAD0_0001, 32'h80);
        peek(32'h0, 32'h0, 1'b0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        chk("redirect_addr2", mem_addr_o, 32'h80);

        // Reset with a request outstanding; late ack must be ignored.
        @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; id_stall_i = 1'b0; mem_ack_i = 1'b0;
        #1;
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
        chk("rst_stall", {31'b0, pc_stall_o}, 32'h1);
        model_reset();
        pc_m = 32'h100;
        @(negedge clk_i);
        rst_i = 1'b1;
        step(0, 0, 0, 1, 32'hFEED_FACE, 32'h0);
        peek(32'h0, 32'h0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 $urandom, $urandom & 32'h0000_0FFC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage sitting directly downstream of the PC register and upstream of decode. Takes the current PC, issues a request/acknowledge fetch to instruction memory of variable latency, and loads the returned word into the IF/ID pipeline register. Drives the PC's stall input so the PC advances only when a fetched instruction is accepted or a branch flush redirects fetch. Handles decode stalls and branch flushes arriving while a fetch is outstanding.

## Interface
- ADDR_W, 32, PC / memory address width
- NOP, 32'h0000_0000, instruction word inserted on bubbles/flushes
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  fetch enable; no new fetch issued while low
- pc_i  in  ADDR_W  current PC (PC register output)
- flush_i  in  1  taken branch/jump resolved in ID; squash wrong-path fetch
- id_stall_i  in  1  hazard unit holds IF/ID (load-use)
- mem_req_o  out  1  instruction memory request, registered
- mem_addr_o  out  ADDR_W  fetch address, registered, stable while mem_req_o=1
- mem_ack_i  in  1  memory returns mem_rdata_i this cycle
- mem_rdata_i  in  32  fetched instruction
- pc_stall_o  out  1  to PC stall input; 0 = PC loads its next value this edge
- if_id_pc_o  out  ADDR_W  PC of instruction in IF/ID
- if_id_instr_o  out  32  instruction in IF/ID
- if_id_valid_o  out  1  IF/ID holds a real instruction

## Operation
- States: IDLE, REQ, HOLD, DROP.
- IDLE: if start_i & ~flush_i: mem_addr_o<=pc_i, mem_req_o<=1, ->REQ. Else stay.
- REQ: mem_req_o=1, address fixed. On mem_ack_i:
  - flush_i: discard data, ->IDLE, mem_req_o<=0.
  - id_stall_i: buffer {mem_addr_o, mem_rdata_i}, ->HOLD, mem_req_o<=0.
  - else accept: IF/ID<={mem_addr_o, mem_rdata_i, valid=1}, ->IDLE, mem_req_o<=0.
  - No ack, flush_i: ->DROP (request stays up until ack).
- HOLD: flush_i: discard buffer, ->IDLE. ~id_stall_i: IF/ID<=buffer, valid=1, ->IDLE. Else stay.
- DROP: mem_req_o=1 until mem_ack_i; data discarded; then ->IDLE. A flush_i here is absorbed (PC redirect still happens).
- pc_stall_o = ~(accept | flush_i), where accept = REQ&ack&~flush_i&~id_stall_i, or HOLD&~id_stall_i&~flush_i.
- IF/ID update priority: flush_i -> {pc 0, NOP, valid 0}; else id_stall_i -> hold; else accept -> load; else bubble {pc 0, NOP, valid 0}.
- mem_ack_i in IDLE/HOLD ignored.
- start_i low does not abort an outstanding request; it completes normally.

## Timing
- Reset: state IDLE, mem_req_o 0, mem_addr_o 0, IF/ID pc 0 / NOP / valid 0, buffer 0. pc_stall_o=1 from IDLE with flush_i=0.
- Zero-wait memory (ack same cycle as req): IDLE cycle N, REQ cycle N+1, IF/ID valid and PC updated at end of N+1. Throughput 1 instr / 2 cycles; each wait cycle adds 1.
- PC update and IF/ID load occur on the same edge; next IDLE cycle latches the new pc_i.
- flush_i and mem_ack_i same cycle: data discarded, PC redirected, IF/ID bubble.
- flush_i and id_stall_i same cycle: flush wins.
- Reset mid-fetch: all state cleared immediately; outstanding memory response after reset is ignored (IDLE).

## Structure
- Shared package cpu_pkg: NOP constant, ADDR_W default, fetch-state enum (IDLE, REQ, HOLD, DROP).
- Sub-module if_id_reg: the IF/ID pipeline register with load/hold/flush controls; FSM, address register and skid buffer stay in ifetch_unit.

## Test plan
- Reset then start_i=1, pc_i=0x0, ack same cycle as req, rdata 0x8C010004 -> IF/ID {0x0, 0x8C010004, 1} after 2 cycles; pc_stall_o=0 for exactly that one cycle.
- pc_i=0x10, ack after 3 wait cycles -> mem_addr_o stays 0x10 with mem_req_o=1 for 4 cycles; pc_stall_o=1 throughout until ack cycle.
- id_stall_i=1 during ack of pc 0x14 data 0x00221820 -> HOLD, IF/ID unchanged, pc_stall_o=1; id_stall_i drops -> IF/ID {0x14, 0x00221820, 1}, PC released that cycle.
- flush_i pulsed while REQ pending for 0x18 -> pc_stall_o=0 that cycle, DROP until ack, returned word never appears in IF/ID, next request address = new pc_i (e.g. 0x40).
- flush_i coincident with ack -> IF/ID {0, NOP, 0}, state IDLE, next fetch at redirected pc_i.
- rst_i asserted in REQ with ack arriving 1 cycle later -> all outputs at reset values, late ack ignored, no IF/ID load.
